l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Two-requester arbiter that shares the single L1-side port of `L2_cache` between the core0 and core1 L1 caches in the two-core system. It latches each core's read/write request and issues one transaction at a time to L2, using round-robin priority. It tracks L2 completion through `L2_busy`, then returns read data and a one-cycle done pulse to the owning core. It sits between the two L1 controllers and the L2 `L1_*` ports.

## Interface
- `n`, 32, data word width.
- `ACK_WAIT`, 4, cycles to wait in ISSUE for `L2_busy` before treating the access as a zero-wait hit; valid range 1–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `core0_word_address`, `core1_word_address`  in  15  word address from each L1.
- `core0_wdata`, `core1_wdata`  in  n  write data from each L1.
- `core0_read_request`, `core0_write_request`, `core1_read_request`, `core1_write_request`  in  1 each  request levels.
- `core0_rdata`, `core1_rdata`  out  n  returned read data, held until that core's next completion.
- `core0_done`, `core1_done`  out  1 each  one-cycle completion pulse.
- `core0_busy`, `core1_busy`  out  1 each  high from grant until done.
- `L1_word_address`  out  15  address to L2.
- `L1_wdata`  out  n  write data to L2.
- `L1_read_request`, `L1_write_request`  out  1 each  request to L2.
- `L1_rdata`  in  n  L2 read data.
- `L2_busy`  in  1  L2 servicing indicator.
- `arb_stat0`, `arb_stat1`  out  32 each  completed-transaction counters per core.

## Operation
- States:
  - IDLE: sample core requests.
  - ISSUE: L2 request driven; wait for `L2_busy`.
  - WAIT: `L2_busy` seen; wait for it to fall.
  - RESP: return data to the granted core.
- A core is requesting when its read or write request is high. If both are high, the request is a write.
- IDLE with exactly one core requesting: grant that core.
- IDLE with both cores requesting: grant the core not equal to `last_grant`. Reset value of `last_grant` is core1, so core0 wins the first tie.
- On grant, latch the core's address, wdata and op into internal registers, set `coreX_busy`, and go to ISSUE. Later changes on the core inputs are ignored until RESP.
- ISSUE/WAIT: `L1_word_address`, `L1_wdata` and the op-matching `L1_*_request` are driven from the latch. Exactly one of `L1_read_request`/`L1_write_request` is high.
- ISSUE: `L2_busy`=1 → WAIT. If `L2_busy` stays 0 for `ACK_WAIT` consecutive cycles → RESP (hit without busy).
- WAIT: `L2_busy`=0 → RESP.
- On entry to RESP:
  - for reads, capture `L1_rdata` into `coreX_rdata`; writes leave it unchanged;
  - pulse `coreX_done`, clear `coreX_busy`, deassert both `L1_*_request`;
  - increment `arb_stat` (wraps at 2^32−1 → 0);
  - set `last_grant` to the granted core.
- RESP → IDLE unconditionally. Cores drop their request during the RESP cycle.
- The non-granted core keeps its request asserted. It is served at the next IDLE sample, not lost.

## Timing
- All outputs are registered.
- Reset values: all requests, busy, done and address outputs are 0; rdata and stats are 0; state is IDLE.
- Reset mid-transaction aborts immediately. No done pulse is issued, and the L2 request drops asynchronously.
- Latency: core request sampled at edge E → `L1_*_request` high after E.
- Completion when `L2_busy` falls: if `L2_busy` first sampled low at edge F, done is high for the cycle after F.
- Minimum turnaround is IDLE→ISSUE→…→RESP→IDLE. A back-to-back request from the other core is granted at the edge after RESP.
- Zero-wait hit: done asserts `ACK_WAIT`+1 edges after the grant edge.
- Per-core `coreX_done` is high for exactly one cycle per transaction. The two cores' done signals are never high in the same cycle.

## Test plan
- Core0 write, addr 1000, data 8; L2 busy for 20 cycles → `L1_write_request`=1 and `L1_word_address`=1000 on the cycle after the request; `core0_done` one pulse; `arb_stat0`=1.
- Core1 read, addr 42; L2 returns `L1_rdata`=0x55 when busy falls → `core1_rdata`=0x55, `core1_done` pulsed; core0 outputs untouched.
- Both cores read in the same cycle after reset → core0 served first, core1 served second. Repeat the tie → core1 first (alternation).
- Read with `L2_busy` never asserted, `ACK_WAIT`=4 → done on the 5th edge after grant; rdata = `L1_rdata` at that edge.
- Core0 read and write both high, addr 7 → only `L1_write_request` asserted.
- Reset low during WAIT → all L2 requests and busy outputs 0 immediately, no done pulse, and the next request after reset is served normally.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter that shares the single L1-side port of the L2 cache between two cores.
// One transaction is in flight at a time: grant, issue to L2, track L2_busy, then respond.
module l2_port_arbiter #(
    parameter int n        = 32,
    parameter int ACK_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [14:0]   core0_word_address,
    input  logic [14:0]   core1_word_address,
    input  logic [n-1:0]  core0_wdata,
    input  logic [n-1:0]  core1_wdata,
    input  logic          core0_read_request,
    input  logic          core0_write_request,
    input  logic          core1_read_request,
    input  logic          core1_write_request,
    output logic [n-1:0]  core0_rdata,
    output logic [n-1:0]  core1_rdata,
    output logic          core0_done,
    output logic          core1_done,
    output logic          core0_busy,
    output logic          core1_busy,
    output logic [14:0]   L1_word_address,
    output logic [n-1:0]  L1_wdata,
    output logic          L1_read_request,
    output logic          L1_write_request,
    input  logic [n-1:0]  L1_rdata,
    input  logic          L2_busy,
    output logic [31:0]   arb_stat0,
    output logic [31:0]   arb_stat1,
    output logic [1:0]    arb_state
);

    // Core side: a core holds its read/write request level until it sees its one-cycle
    // done pulse; busy is high from grant to done. L2 side: the registered request stays
    // high until L2_busy has risen and fallen again, or ACK_WAIT+1 idle samples pass.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] ACK_LIMIT = 4'(ACK_WAIT);

    state_t      state;
    state_t      state_next;
    logic        req0;
    logic        req1;
    logic        grant_valid;
    logic        grant_sel;
    logic        wr_sel;
    logic        owner;
    logic        last_grant;
    logic        resp_entry;
    logic [3:0]  wait_cnt;

    assign req0      = core0_read_request | core0_write_request;
    assign req1      = core1_read_request | core1_write_request;
    assign arb_state = state;

    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_valid = 1'b1;
                    grant_sel   = ~last_grant;
                end else if (req0) begin
                    grant_valid = 1'b1;
                end else if (req1) begin
                    grant_valid = 1'b1;
                    grant_sel   = 1'b1;
                end
                if (grant_valid) state_next = ISSUE;
            end
            ISSUE: begin
                if (L2_busy) state_next = WAIT;
                else if (wait_cnt == ACK_LIMIT) state_next = RESP;
            end
            WAIT: begin
                if (!L2_busy) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign resp_entry = (state != RESP) && (state_next == RESP);
    // A simultaneous read and write from one core is treated as a write.
    assign wr_sel     = grant_sel ? core1_write_request : core0_write_request;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            owner            <= 1'b0;
            last_grant       <= 1'b1;
            wait_cnt         <= '0;
            L1_word_address  <= '0;
            L1_wdata         <= '0;
            L1_read_request  <= 1'b0;
            L1_write_request <= 1'b0;
            core0_busy       <= 1'b0;
            core1_busy       <= 1'b0;
            core0_done       <= 1'b0;
            core1_done       <= 1'b0;
            core0_rdata      <= '0;
            core1_rdata      <= '0;
            arb_stat0        <= '0;
            arb_stat1        <= '0;
        end else begin
            state      <= state_next;
            core0_done <= resp_entry && !owner;
            core1_done <= resp_entry && owner;
            if (grant_valid) begin
                owner            <= grant_sel;
                wait_cnt         <= '0;
                L1_word_address  <= grant_sel ? core1_word_address : core0_word_address;
                L1_wdata         <= grant_sel ? core1_wdata : core0_wdata;
                L1_write_request <= wr_sel;
                L1_read_request  <= ~wr_sel;
                core0_busy       <= ~grant_sel;
                core1_busy       <= grant_sel;
            end
            if (state == ISSUE && state_next == ISSUE) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (resp_entry) begin
                L1_read_request  <= 1'b0;
                L1_write_request <= 1'b0;
                core0_busy       <= 1'b0;
                core1_busy       <= 1'b0;
                last_grant       <= owner;
                if (!owner) begin
                    arb_stat0 <= arb_stat0 + 32'd1;
                    if (L1_read_request) core0_rdata <= L1_rdata;
                end else begin
                    arb_stat1 <= arb_stat1 + 32'd1;
                    if (L1_read_request) core1_rdata <= L1_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: core drivers, a behavioural L2 memory, and a scoreboard
// that checks returned data and per-core counters on every done pulse.
module tb_l2_port_arbiter;

    localparam int N        = 32;
    localparam int ACK_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [14:0]   core0_word_address, core1_word_address;
    logic [N-1:0]  core0_wdata, core1_wdata;
    logic          core0_read_request, core0_write_request;
    logic          core1_read_request, core1_write_request;
    logic [N-1:0]  core0_rdata, core1_rdata;
    logic          core0_done, core1_done, core0_busy, core1_busy;
    logic [14:0]   L1_word_address;
    logic [N-1:0]  L1_wdata;
    logic          L1_read_request, L1_write_request;
    logic [N-1:0]  L1_rdata;
    logic          L2_busy;
    logic [31:0]   arb_stat0, arb_stat1;
    logic [1:0]    arb_state;

    l2_port_arbiter #(.n(N), .ACK_WAIT(ACK_WAIT)) dut (
        .clk(clk), .reset(reset),
        .core0_word_address(core0_word_address), .core1_word_address(core1_word_address),
        .core0_wdata(core0_wdata), .core1_wdata(core1_wdata),
        .core0_read_request(core0_read_request), .core0_write_request(core0_write_request),
        .core1_read_request(core1_read_request), .core1_write_request(core1_write_request),
        .core0_rdata(core0_rdata), .core1_rdata(core1_rdata),
        .core0_done(core0_done), .core1_done(core1_done),
        .core0_busy(core0_busy), .core1_busy(core1_busy),
        .L1_word_address(L1_word_address), .L1_wdata(L1_wdata),
        .L1_read_request(L1_read_request), .L1_write_request(L1_write_request),
        .L1_rdata(L1_rdata), .L2_busy(L2_busy),
        .arb_stat0(arb_stat0), .arb_stat1(arb_stat1), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    // Reference model and scoreboard state
    logic [63:0]  exp_q0[$];
    logic [63:0]  exp_q1[$];
    int           done_log[$];
    logic [31:0]  ref_mem[logic [14:0]];
    logic [31:0]  l2_mem[logic [14:0]];
    logic [31:0]  stat_ref[2];
    logic [31:0]  last_rd[2];
    int           l2_lat;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         snap_rd, snap_wr, snap_busy;
    logic [14:0]  snap_addr;
    logic [31:0]  snap_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [14:0] a);
        return 32'hC0DE_0000 | {17'd0, a};
    endfunction

    function automatic logic [31:0] ref_read(input logic [14:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] l2_read(input logic [14:0] a);
        return l2_mem.exists(a) ? l2_mem[a] : init_val(a);
    endfunction

    task automatic clear_model();
        exp_q0.delete();
        exp_q1.delete();
        done_log.delete();
        stat_ref[0] = '0;
        stat_ref[1] = '0;
        last_rd[0]  = '0;
        last_rd[1]  = '0;
    endtask

    // Issue one request from core c, wait for its done pulse, then drop the request.
    task automatic do_req(input int c, input logic rd, input logic wr, input logic [14:0] addr,
                          input logic [31:0] data, output int lat);
        logic [31:0] exp_rd;
        @(negedge clk);
        if (c == 0) begin
            core0_word_address = addr; core0_wdata = data;
            core0_read_request = rd;   core0_write_request = wr;
        end else begin
            core1_word_address = addr; core1_wdata = data;
            core1_read_request = rd;   core1_write_request = wr;
        end
        if (wr) begin
            ref_mem[addr] = data;
            exp_rd = last_rd[c];
        end else begin
            exp_rd = ref_read(addr);
            last_rd[c] = exp_rd;
        end
        stat_ref[c] = stat_ref[c] + 32'd1;
        if (c == 0) exp_q0.push_back({stat_ref[0], exp_rd});
        else        exp_q1.push_back({stat_ref[1], exp_rd});
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                snap_rd    = L1_read_request;
                snap_wr    = L1_write_request;
                snap_addr  = L1_word_address;
                snap_wdata = L1_wdata;
                snap_busy  = (c == 0) ? core0_busy : core1_busy;
            end
            if ((c == 0 && core0_done) || (c == 1 && core1_done)) break;
            if (lat > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_core%0d: no done after %0d cycles, required a done pulse", c, lat);
                break;
            end
            // Once granted, the core's address/data must no longer matter.
            if (c == 0 && core0_busy) begin
                core0_word_address = 15'($urandom); core0_wdata = $urandom;
            end
            if (c == 1 && core1_busy) begin
                core1_word_address = 15'($urandom); core1_wdata = $urandom;
            end
        end
        if (c == 0) begin
            core0_read_request = 1'b0; core0_write_request = 1'b0;
        end else begin
            core1_read_request = 1'b0; core1_write_request = 1'b0;
        end
    endtask

    // Behavioural L2: l2_lat < 0 picks a random latency, 0 is a hit without busy.
    initial begin
        bit   prev_req;
        int   busy_left;
        int   lat;
        L2_busy   = 1'b0;
        L1_rdata  = '0;
        prev_req  = 1'b0;
        busy_left = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req  = 1'b0;
                busy_left = 0;
                L2_busy   = 1'b0;
            end else begin
                if ((L1_read_request || L1_write_request) && !prev_req) begin
                    if (L1_write_request) begin
                        l2_mem[L1_word_address] = L1_wdata;
                        L1_rdata = $urandom;
                    end else begin
                        L1_rdata = l2_read(L1_word_address);
                    end
                    lat = l2_lat;
                    if (lat < 0) lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
                    if (lat > 0) begin
                        L2_busy   = 1'b1;
                        busy_left = lat;
                    end
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) L2_busy = 1'b0;
                end
                prev_req = L1_read_request || L1_write_request;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [63:0] e;
        logic        prev_d0;
        logic        prev_d1;
        prev_d0 = 1'b0;
        prev_d1 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (core0_done || core1_done)
                    check("done_exclusive", 64'(core0_done & core1_done), 64'd0);
                if (core0_done) begin
                    check("done0_one_cycle", 64'(prev_d0), 64'd0);
                    done_log.push_back(0);
                    if (exp_q0.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL core0_done_unexpected: done with no outstanding request, required none");
                    end else begin
                        e = exp_q0.pop_front();
                        check("core0_rdata", 64'(core0_rdata), 64'(e[31:0]));
                        check("arb_stat0", 64'(arb_stat0), 64'(e[63:32]));
                    end
                end
                if (core1_done) begin
                    check("done1_one_cycle", 64'(prev_d1), 64'd0);
                    done_log.push_back(1);
                    if (exp_q1.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL core1_done_unexpected: done with no outstanding request, required none");
                    end else begin
                        e = exp_q1.pop_front();
                        check("core1_rdata", 64'(core1_rdata), 64'(e[31:0]));
                        check("arb_stat1", 64'(arb_stat1), 64'(e[63:32]));
                    end
                end
            end
            prev_d0 = core0_done;
            prev_d1 = core1_done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0, l1;
        reset = 1'b0;
        core0_word_address = '0; core1_word_address = '0;
        core0_wdata = '0; core1_wdata = '0;
        core0_read_request = 1'b0; core0_write_request = 1'b0;
        core1_read_request = 1'b0; core1_write_request = 1'b0;
        l2_lat = -1;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_L1_read_request", 64'(L1_read_request), 64'd0);
        check("rst_L1_write_request", 64'(L1_write_request), 64'd0);
        check("rst_L1_word_address", 64'(L1_word_address), 64'd0);
        check("rst_core_busy", 64'({core0_busy, core1_busy}), 64'd0);
        check("rst_core_done", 64'({core0_done, core1_done}), 64'd0);
        check("rst_core0_rdata", 64'(core0_rdata), 64'd0);
        check("rst_core1_rdata", 64'(core1_rdata), 64'd0);
        check("rst_arb_stats", {arb_stat1, arb_stat0}, 64'd0);

        // Tie right after reset: core0 first, then core1.
        done_log.delete();
        fork
            do_req(0, 1'b1, 1'b0, 15'd100, 32'd0, l0);
            do_req(1, 1'b1, 1'b0, 15'd101, 32'd0, l1);
        join
        check("tie1_count", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) begin
            check("tie1_first", 64'(done_log[0]), 64'd0);
            check("tie1_second", 64'(done_log[1]), 64'd1);
        end
        // Core0 served alone, so the next tie goes to core1.
        do_req(0, 1'b1, 1'b0, 15'd102, 32'd0, l0);
        done_log.delete();
        fork
            do_req(0, 1'b1, 1'b0, 15'd104, 32'd0, l0);
            do_req(1, 1'b1, 1'b0, 15'd105, 32'd0, l1);
        join
        check("tie2_count", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) begin
            check("tie2_first", 64'(done_log[0]), 64'd1);
            check("tie2_second", 64'(done_log[1]), 64'd0);
        end

        // Core0 write, addr 1000, data 8, L2 busy for 20 cycles.
        l2_lat = 20;
        do_req(0, 1'b0, 1'b1, 15'd1000, 32'd8, l0);
        check("wr_L1_write_request", 64'(snap_wr), 64'd1);
        check("wr_L1_read_request", 64'(snap_rd), 64'd0);
        check("wr_L1_word_address", 64'(snap_addr), 64'd1000);
        check("wr_L1_wdata", 64'(snap_wdata), 64'd8);
        check("wr_core0_busy", 64'(snap_busy), 64'd1);
        check("wr_latency", 64'(l0), 64'd22);

        // Core1 read of addr 42 returning 0x55; core0 outputs untouched.
        l2_mem[15'd42]  = 32'h55;
        ref_mem[15'd42] = 32'h55;
        l2_lat = 5;
        do_req(1, 1'b1, 1'b0, 15'd42, 32'd0, l1);
        check("rd42_core0_rdata_kept", 64'(core0_rdata), 64'(last_rd[0]));
        check("rd42_arb_stat0_kept", 64'(arb_stat0), 64'(stat_ref[0]));

        // Zero-wait hit: done on the (ACK_WAIT+1)th edge after the grant edge.
        l2_lat = 0;
        do_req(0, 1'b1, 1'b0, 15'd5, 32'd0, l0);
        check("zero_wait_latency", 64'(l0), 64'(ACK_WAIT + 2));

        // Read and write both high: only the write reaches L2.
        l2_lat = 2;
        do_req(0, 1'b1, 1'b1, 15'd7, 32'hDEAD_BEEF, l0);
        check("rw_L1_write_request", 64'(snap_wr), 64'd1);
        check("rw_L1_read_request", 64'(snap_rd), 64'd0);
        check("rw_L1_word_address", 64'(snap_addr), 64'd7);

        // Reset in WAIT aborts at once.
        l2_lat = 30;
        @(negedge clk);
        core0_word_address = 15'd9;
        core0_read_request = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_state", 64'(arb_state), 64'd2);
        check("pre_reset_busy", 64'(core0_busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_L1_requests", 64'({L1_read_request, L1_write_request}), 64'd0);
        check("mid_reset_busy", 64'({core0_busy, core1_busy}), 64'd0);
        check("mid_reset_done", 64'({core0_done, core1_done}), 64'd0);
        check("mid_reset_stat0", 64'(arb_stat0), 64'd0);
        core0_read_request = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        l2_lat = 3;
        do_req(0, 1'b1, 1'b0, 15'd9, 32'd0, l0);
        check("post_reset_stat0", 64'(arb_stat0), 64'd1);

        // Randomized traffic from both cores on disjoint address sets.
        l2_lat = -1;
        fork
            begin
                int la;
                int k;
                for (int i = 0; i < 25; i++) begin
                    k = int'($urandom_range(0, 2));
                    do_req(0, k != 1, k != 0, {10'd0, 4'($urandom_range(0, 15)), 1'b0}, $urandom, la);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                int lb;
                int k;
                for (int i = 0; i < 25; i++) begin
                    k = int'($urandom_range(0, 2));
                    do_req(1, k != 1, k != 0, {10'd0, 4'($urandom_range(0, 15)), 1'b1}, $urandom, lb);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join
        repeat (5) @(negedge clk);
        check("final_q0_empty", 64'(exp_q0.size()), 64'd0);
        check("final_q1_empty", 64'(exp_q1.size()), 64'd0);
        check("final_arb_stat0", 64'(arb_stat0), 64'(stat_ref[0]));
        check("final_arb_stat1", 64'(arb_stat1), 64'(stat_ref[1]));
        check("final_idle_busy", 64'({core0_busy, core1_busy}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
